// File: rtl/vector_sequencer.sv
// Vector display sequencer: queues JUMP/DRAW commands and streams X/Y words to a
// DAC, rasterising DRAW lines with Bresenham steps. Asynchronous active-high reset.
module vector_sequencer #(
  parameter int W     = 12,
  parameter int DEPTH = 8,
  parameter int ZW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [W-1:0]  cmd_x,
  input  logic [W-1:0]  cmd_y,
  input  logic [ZW-1:0] cmd_z,
  output logic          dac_valid,
  input  logic          dac_ready,
  output logic [W-1:0]  dac_value,
  output logic          dac_axis,
  output logic [ZW-1:0] z_out,
  output logic          blank,
  output logic          busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 1 + ZW + 2 * W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND_X,
    S_SEND_Y,
    S_STEP
  } state_t;

  typedef logic signed [W+1:0] sw_t;
  typedef logic signed [W+2:0] sw2_t;

  // Command FIFO
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop;
  logic [EW-1:0] head;
  logic          head_op;
  logic [ZW-1:0] head_z;
  logic [W-1:0]  head_x, head_y;

  // Sequencer state
  state_t        state_q, state_d;
  logic [W-1:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [W-1:0]  tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic          op_q, op_d;
  logic [ZW-1:0] z_q, z_d;
  logic          blank_q, blank_d;
  sw_t           dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic          sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic          send_y_q, send_y_d;

  sw_t           diff_x, diff_y, abs_x, abs_y;
  sw2_t          e2, dx_ext, dy_ext;
  logic          step_x, step_y, at_target;

  assign cmd_ready = !reset && (count_q != FULL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage array has no reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_z, cmd_x, cmd_y};
  end

  assign head    = mem_q[rd_ptr_q];
  assign head_op = head[EW-1];
  assign head_z  = head[2*W +: ZW];
  assign head_x  = head[W +: W];
  assign head_y  = head[0 +: W];

  // Line setup and step decision; e2 needs one extra bit over err.
  assign diff_x    = $signed({2'b00, tgt_x_q}) - $signed({2'b00, cur_x_q});
  assign diff_y    = $signed({2'b00, tgt_y_q}) - $signed({2'b00, cur_y_q});
  assign abs_x     = diff_x[W+1] ? -diff_x : diff_x;
  assign abs_y     = diff_y[W+1] ? -diff_y : diff_y;
  assign e2        = $signed({err_q, 1'b0});
  assign dx_ext    = $signed({dx_q[W+1], dx_q});
  assign dy_ext    = $signed({dy_q[W+1], dy_q});
  assign step_x    = (e2 >= dy_ext);
  assign step_y    = (e2 <= dx_ext);
  assign at_target = (cur_x_q == tgt_x_q) && (cur_y_q == tgt_y_q);

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    tgt_x_d  = tgt_x_q;
    tgt_y_d  = tgt_y_q;
    op_d     = op_q;
    z_d      = z_q;
    blank_d  = blank_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    send_y_d = send_y_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          tgt_x_d = head_x;
          tgt_y_d = head_y;
          op_d    = head_op;
          z_d     = head_op ? head_z : '0;
          blank_d = !head_op;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        send_y_d = 1'b1;
        state_d  = S_SEND_X;
        if (!op_q) begin
          cur_x_d = tgt_x_q;
          cur_y_d = tgt_y_q;
        end else if (!at_target) begin
          dx_d     = abs_x;
          dy_d     = -abs_y;
          err_d    = abs_x - abs_y;
          sx_neg_d = diff_x[W+1];
          sy_neg_d = diff_y[W+1];
          state_d  = S_STEP;
        end
      end
      S_STEP: begin
        if (step_x) cur_x_d = sx_neg_q ? cur_x_q - W'(1) : cur_x_q + W'(1);
        if (step_y) cur_y_d = sy_neg_q ? cur_y_q - W'(1) : cur_y_q + W'(1);
        err_d    = err_q + (step_x ? dy_q : sw_t'(0)) + (step_y ? dx_q : sw_t'(0));
        send_y_d = step_y;
        state_d  = step_x ? S_SEND_X : S_SEND_Y;
      end
      S_SEND_X: begin
        if (dac_ready) begin
          if (send_y_q)       state_d = S_SEND_Y;
          else if (at_target) state_d = S_IDLE;
          else                state_d = S_STEP;
        end
      end
      S_SEND_Y: begin
        if (dac_ready) state_d = at_target ? S_IDLE : S_STEP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      tgt_x_q  <= '0;
      tgt_y_q  <= '0;
      op_q     <= 1'b0;
      z_q      <= '0;
      blank_q  <= 1'b1;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      send_y_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      tgt_x_q  <= tgt_x_d;
      tgt_y_q  <= tgt_y_d;
      op_q     <= op_d;
      z_q      <= z_d;
      blank_q  <= blank_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      send_y_q <= send_y_d;
    end
  end

  // Position is frozen in the SEND states, so the DAC word is stable while stalled.
  assign dac_valid = (state_q == S_SEND_X) || (state_q == S_SEND_Y);
  assign dac_axis  = (state_q == S_SEND_Y);
  assign dac_value = (state_q == S_SEND_X) ? cur_x_q :
                     (state_q == S_SEND_Y) ? cur_y_q : '0;
  assign z_out     = z_q;
  assign blank     = blank_q;
  assign busy      = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: expected DAC transfers are queued when each
// command is offered and compared as the DUT completes transfers.
module tb_vector_sequencer;

  localparam int W     = 12;
  localparam int DEPTH = 4;
  localparam int ZW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_op = 1'b0;
  logic [W-1:0]  cmd_x = '0;
  logic [W-1:0]  cmd_y = '0;
  logic [ZW-1:0] cmd_z = '0;
  logic          dac_valid;
  logic          dac_ready = 1'b0;
  logic [W-1:0]  dac_value;
  logic          dac_axis;
  logic [ZW-1:0] z_out;
  logic          blank;
  logic          busy;

  vector_sequencer #(.W(W), .DEPTH(DEPTH), .ZW(ZW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_z     (cmd_z),
    .dac_valid (dac_valid),
    .dac_ready (dac_ready),
    .dac_value (dac_value),
    .dac_axis  (dac_axis),
    .z_out     (z_out),
    .blank     (blank),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          axis;
    logic [W-1:0]  value;
    logic [ZW-1:0] z;
    logic          blank;
  } xfer_t;

  xfer_t        exp_q[$];
  int           checks = 0;
  int           failures = 0;
  int           nxfer = 0;
  int           mdl_x = 0;
  int           mdl_y = 0;
  logic         hs = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_value = '0;
  logic         prev_axis = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expd);
    end
  endtask

  task automatic add_xfer(input logic axis, input int v, input int z, input logic bl);
    xfer_t e;
    e.axis  = axis;
    e.value = v[W-1:0];
    e.z     = z[ZW-1:0];
    e.blank = bl;
    exp_q.push_back(e);
  endtask

  // Reference model: transfers a command must produce from the model position.
  task automatic expect_cmd(input logic op, input int x1, input int y1, input int z);
    int dx, dy, sx, sy, err, e2, x, y, guard;
    logic cx, cy;
    if (!op) begin
      add_xfer(1'b0, x1, 0, 1'b1);
      add_xfer(1'b1, y1, 0, 1'b1);
    end else if (x1 == mdl_x && y1 == mdl_y) begin
      add_xfer(1'b0, x1, z, 1'b0);
      add_xfer(1'b1, y1, z, 1'b0);
    end else begin
      dx  = (x1 > mdl_x) ? x1 - mdl_x : mdl_x - x1;
      dy  = -((y1 > mdl_y) ? y1 - mdl_y : mdl_y - y1);
      sx  = (x1 >= mdl_x) ? 1 : -1;
      sy  = (y1 >= mdl_y) ? 1 : -1;
      err = dx + dy;
      x   = mdl_x;
      y   = mdl_y;
      guard = 0;
      while ((x != x1 || y != y1) && guard < 20000) begin
        e2 = 2 * err;
        cx = 1'b0;
        cy = 1'b0;
        if (e2 >= dy) begin err += dy; x += sx; cx = 1'b1; end
        if (e2 <= dx) begin err += dx; y += sy; cy = 1'b1; end
        if (cx) add_xfer(1'b0, x, z, 1'b0);
        if (cy) add_xfer(1'b1, y, z, 1'b0);
        guard++;
      end
    end
    mdl_x = x1;
    mdl_y = y1;
  endtask

  // Negedge sample: handshake capture, stall stability and scoreboard compare.
  task automatic sample();
    xfer_t e;
    @(negedge clk);
    hs = cmd_valid && cmd_ready;
    if (prev_stall) begin
      check("hold_valid", 32'(dac_valid), 32'd1);
      check("hold_value", 32'(dac_value), 32'(prev_value));
      check("hold_axis", 32'(dac_axis), 32'(prev_axis));
    end
    if (dac_valid && dac_ready) begin
      nxfer++;
      checks++;
      assert (exp_q.size() != 0)
      else begin
        failures++;
        $error("FAIL unexpected_xfer observed=axis%0d/%0d expected=none", dac_axis, dac_value);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("xfer_axis", 32'(dac_axis), 32'(e.axis));
        check("xfer_value", 32'(dac_value), 32'(e.value));
        check("xfer_z", 32'(z_out), 32'(e.z));
        check("xfer_blank", 32'(blank), 32'(e.blank));
      end
    end
    prev_stall = dac_valid && !dac_ready;
    prev_value = dac_value;
    prev_axis  = dac_axis;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic push_cmd(input logic op, input int x, input int y, input int z, input string tag);
    int n;
    expect_cmd(op, x, y, z);
    cmd_op    = op;
    cmd_x     = x[W-1:0];
    cmd_y     = y[W-1:0];
    cmd_z     = z[ZW-1:0];
    cmd_valid = 1'b1;
    n = 0;
    do begin
      sample();
      advance();
      n++;
    end while (!hs && n < 200);
    cmd_valid = 1'b0;
    check({"accept_", tag}, 32'(hs), 32'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle_check(input string tag, input logic bl, input int z);
    sample();
    check({"busy_fall_", tag}, 32'(busy), 32'd0);
    check({"blank_hold_", tag}, 32'(blank), 32'(bl));
    check({"z_hold_", tag}, 32'(z_out), 32'(z[ZW-1:0]));
    advance();
  endtask

  initial begin
    int   base, n;
    logic found;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dac_valid", 32'(dac_valid), 32'd0);
    check("rst_dac_value", 32'(dac_value), 32'd0);
    check("rst_dac_axis", 32'(dac_axis), 32'd0);
    check("rst_z_out", 32'(z_out), 32'd0);
    check("rst_blank", 32'(blank), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    advance();
    sample();
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    advance();

    // JUMP(100,200) with latency to first DAC word
    dac_ready = 1'b1;
    push_cmd(1'b0, 100, 200, 0, "j1");
    sample(); check("j1_lat_idle", 32'(dac_valid), 32'd0); advance();
    sample();
    check("j1_lat_load", 32'(dac_valid), 32'd0);
    check("j1_load_blank", 32'(blank), 32'd1);
    check("j1_load_z", 32'(z_out), 32'd0);
    advance();
    sample(); check("j1_lat_send", 32'(dac_valid), 32'd1); advance();
    drain("j1", 20);
    idle_check("j1", 1'b1, 0);

    // DRAW(103,201,z=5): X101; X102,Y201; X103
    push_cmd(1'b1, 103, 201, 5, "d1");
    sample(); check("d1_lat_idle", 32'(dac_valid), 32'd0); advance();
    sample();
    check("d1_lat_load", 32'(dac_valid), 32'd0);
    check("d1_load_blank", 32'(blank), 32'd0);
    check("d1_load_z", 32'(z_out), 32'd5);
    advance();
    sample(); check("d1_lat_step", 32'(dac_valid), 32'd0); advance();
    sample(); check("d1_lat_send", 32'(dac_valid), 32'd1); advance();
    drain("d1", 30);
    idle_check("d1", 1'b0, 5);

    // DRAW with a 10-cycle DAC stall mid-line
    push_cmd(1'b1, 110, 206, 9, "d2");
    repeat (6) cycle();
    dac_ready = 1'b0;
    repeat (10) cycle();
    sample(); check("d2_stalled_valid", 32'(dac_valid), 32'd1); advance();
    dac_ready = 1'b1;
    drain("d2", 100);
    idle_check("d2", 1'b0, 9);

    // Dot: DRAW to the current position
    push_cmd(1'b0, 50, 50, 0, "j2");
    drain("j2", 20);
    push_cmd(1'b1, 50, 50, 7, "dot");
    drain("dot", 20);
    idle_check("dot", 1'b0, 7);

    // Full-range endpoints
    push_cmd(1'b0, 0, 4095, 0, "j3");
    drain("j3", 20);
    push_cmd(1'b1, 4095, 0, 3, "diag");
    drain("diag", 20000);
    push_cmd(1'b1, 4000, 4095, 1, "steep");
    drain("steep", 20000);
    idle_check("steep", 1'b0, 1);

    // FIFO full backpressure with the DAC stalled
    dac_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_cmd(1'b0, i * 10, i * 20, 0, "fill");
    sample();
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    advance();
    expect_cmd(1'b0, 60, 120, 0);
    cmd_op = 1'b0; cmd_x = 12'd60; cmd_y = 12'd120; cmd_z = '0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("full_refuse", 32'(hs), 32'd0);
      advance();
    end
    base = nxfer;
    dac_ready = 1'b1;
    n = 0;
    do begin
      sample();
      advance();
      n++;
    end while (!hs && n < 100);
    cmd_valid = 1'b0;
    check("accept_sixth", 32'(hs), 32'd1);
    check("sixth_after_xfer", 32'(nxfer > base), 32'd1);
    drain("fifo", 100);
    idle_check("fifo", 1'b1, 0);

    // Reset mid-DRAW with three commands queued
    push_cmd(1'b1, 4000, 3000, 4, "long");
    for (int i = 0; i < 3; i++) push_cmd(1'b0, 7, 8, 0, "queued");
    found = 1'b0;
    base = nxfer;
    n = 0;
    while (!found && n < 400) begin
      sample();
      if (nxfer > base + 4 && !dac_valid) found = 1'b1;
      else advance();
      n++;
    end
    check("rst_hit_step", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_dac_valid", 32'(dac_valid), 32'd0);
    check("mid_rst_dac_value", 32'(dac_value), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_blank", 32'(blank), 32'd1);
    check("mid_rst_z", 32'(z_out), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    prev_stall = 1'b0;
    exp_q.delete();
    mdl_x = 0;
    mdl_y = 0;
    advance();
    check("rst_next_dac_valid", 32'(dac_valid), 32'd0);
    check("rst_next_busy", 32'(busy), 32'd0);
    check("rst_next_blank", 32'(blank), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    advance();
    repeat (20) cycle();
    sample();
    check("post_rst_idle_busy", 32'(busy), 32'd0);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    advance();

    // Position restarts from (0,0) after reset
    push_cmd(1'b1, 2, 1, 2, "post");
    drain("post", 30);
    idle_check("post", 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_sequencer.md
VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 Parameters SHALL be:
- W, default 12, coordinate and DAC word width.
- DEPTH, default 8, command FIFO depth (power of 2, >=2).
- ZW, default 4, intensity width.

REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept.
- cmd_op  in  1  0=JUMP, 1=DRAW.
- cmd_x  in  W  target X.
- cmd_y  in  W  target Y.
- cmd_z  in  ZW  DRAW intensity.
- dac_valid  out  1  dac_value/dac_axis valid.
- dac_ready  in  1  DAC accepts word.
- dac_value  out  W  coordinate word.
- dac_axis  out  1  0=X, 1=Y.
- z_out  out  ZW  beam intensity.
- blank  out  1  beam off.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Function
REQ-003 Commands SHALL be pushed into a DEPTH-entry FIFO {op,z,x,y} when cmd_valid && cmd_ready; cmd_ready = (count != DEPTH).
REQ-004 When the FIFO is full, a push SHALL be refused even if a pop occurs in the same cycle; simultaneous push and pop when not full SHALL leave count unchanged.
REQ-005 FSM states SHALL be IDLE, LOAD, SEND_X, SEND_Y, STEP.
- IDLE->LOAD when FIFO non-empty: pop one entry.
- LOAD->SEND_X on JUMP, or on zero-length DRAW (target == current).
- LOAD->STEP on any other DRAW.
REQ-006 DAC transfer SHALL occur on a cycle with dac_valid && dac_ready. While dac_valid && !dac_ready, dac_value and dac_axis SHALL be held stable; dac_valid SHALL NOT drop before the transfer completes.
REQ-007 JUMP:
- blank=1 and z_out=0 from LOAD until the Y transfer completes.
- Current position := target.
- X word SHALL transfer, then Y word, always both.
- Then IDLE; blank remains 1.
REQ-008 DRAW setup in LOAD:
- Widths: dx=|x1-x0|, dy=-|y1-y0|, err=dx+dy, all W+2-bit signed.
- Step directions taken from the sign of the differences.
- blank=0, z_out=cmd_z.
REQ-009 STEP SHALL compute one Bresenham step per entry, using e2=2*err:
- If e2>=dy: err+=dy, x+=sx.
- If e2<=dx: err+=dx, y+=sy.
- Both updates use the pre-step err.
REQ-010 Each step point SHALL be emitted by transferring only changed axes, X before Y, then returning to STEP.
- The start point is not emitted.
- The end point is emitted.
- After the end point's last transfer: IDLE.
REQ-011 Zero-length DRAW SHALL emit X then Y at the current position with z_out=cmd_z (dot).
REQ-012 Coordinates SHALL NOT wrap: Bresenham terminates exactly at the target for all W-bit endpoints, including 0 and 2^W-1.
REQ-013 LOAD SHALL last exactly one cycle. The first dac_valid SHALL assert the cycle after LOAD for JUMP, and the cycle after the first STEP for DRAW.
REQ-014 After a command completes, z_out and blank SHALL hold until the next LOAD. busy SHALL fall the cycle after the final transfer if the FIFO is empty.

Reset
REQ-015 Asserting reset SHALL immediately force the following, regardless of state, including mid-transfer:
- state=IDLE, FIFO empty, current position=(0,0).
- dac_valid=0, dac_value=0, dac_axis=0.
- z_out=0, blank=1, busy=0.
- cmd_ready=0 while reset is high, 1 the cycle after release.
REQ-016 No in-flight or queued command SHALL survive reset.

Verification
REQ-017 Reset, dac_ready=1, JUMP(100,200) -> transfers X=100 (axis 0) then Y=200 (axis 1); blank=1 throughout; busy falls after Y.
REQ-018 From (100,200), DRAW(103,201,z=5) -> transfers X101; X102,Y201; X103 (4 transfers); z_out=5, blank=0.
REQ-019 DRAW with dac_ready held 0 for 10 cycles mid-line -> dac_valid held 1; dac_value/dac_axis unchanged; no step lost.
REQ-020 DEPTH=4, dac_ready=0, push 6 commands -> first popped; cmd_ready low after 4 queued; 6th held off until a transfer frees a slot.
REQ-021 Reset asserted during a DRAW STEP with 3 queued -> next cycle dac_valid=0, busy=0, blank=1; after release no stale transfers occur.
REQ-022 DRAW to the current position (50,50), z=7 -> one X=50 and one Y=50 transfer with z_out=7; then IDLE.
